// File: rtl/arb_pkg.sv
// Shared types and constants for the priority arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_enc_masked.sv
// Combinational priority encoder: finds the first set request searching
// downward from a start index, wrapping from 0 back to N-1.
module prio_enc_masked #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl_s;

    assign dbl_s = {req, req};

    // Window start+1 .. start+N of the doubled vector covers every requester
    // once, with start itself at the top; the highest set bit there wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < 2 * N; j++) begin
            if (dbl_s[j] && (j > int'(start)) && (j <= int'(start) + N)) begin
                found = 1'b1;
                idx   = (j >= N) ? W'(j - N) : W'(j);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter, fixed-priority or round-robin, with a
// valid/ready grant handshake that holds the winner until accepted.
module prio_arbiter
    import arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    arb_state_e   state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         gnt_valid_q, gnt_valid_d;
    logic [W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0] gnt_onehot_q, gnt_onehot_d;

    logic         accept_s;
    logic [W-1:0] ptr_post_s;
    logic [W-1:0] start_s;
    logic         enc_found_s;
    logic [W-1:0] enc_idx_s;

    assign accept_s = gnt_valid_q & gnt_ready;

    // Pointer as it stands after this cycle's accept; the re-arbitration
    // in the same cycle must already search from it.
    always_comb begin
        ptr_post_s = ptr_q;
        if (accept_s && (mode == MODE_RR)) begin
            ptr_post_s = (gnt_idx_q == '0) ? LAST_IDX : gnt_idx_q - W'(1);
        end else begin
            ptr_post_s = ptr_q;
        end
    end

    assign start_s = (mode == MODE_FIXED) ? LAST_IDX : ptr_post_s;

    prio_enc_masked #(.N(N), .W(W)) u_enc (
        .req   (req),
        .start (start_s),
        .found (enc_found_s),
        .idx   (enc_idx_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        case (state_q)
            IDLE: begin
                if (enc_found_s) begin
                    state_d      = GRANT;
                    gnt_valid_d  = 1'b1;
                    gnt_idx_d    = enc_idx_s;
                    gnt_onehot_d = ONE_HOT0 << enc_idx_s;
                end else begin
                    gnt_valid_d  = 1'b0;
                    gnt_idx_d    = '0;
                    gnt_onehot_d = '0;
                end
            end
            GRANT: begin
                if (accept_s) begin
                    ptr_d = ptr_post_s;
                    if (enc_found_s) begin
                        gnt_idx_d    = enc_idx_s;
                        gnt_onehot_d = ONE_HOT0 << enc_idx_s;
                    end else begin
                        state_d      = IDLE;
                        gnt_valid_d  = 1'b0;
                        gnt_idx_d    = '0;
                        gnt_onehot_d = '0;
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d      = IDLE;
                ptr_d        = LAST_IDX;
                gnt_valid_d  = 1'b0;
                gnt_idx_d    = '0;
                gnt_onehot_d = '0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= LAST_IDX;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: N=8 and N=5 instances checked every cycle against
// a behavioural model, plus directed literal expectations.
module tb_prio_arbiter;

    logic       clk = 1'b0;
    logic       rst_a, mode_a, rdy_a;
    logic [7:0] req_a;
    logic       v_a;
    logic [2:0] idx_a;
    logic [7:0] oh_a;

    logic       rst_b, mode_b, rdy_b;
    logic [4:0] req_b;
    logic       v_b;
    logic [2:0] idx_b;
    logic [4:0] oh_b;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int ma_valid, ma_idx, ma_ptr;
    int mb_valid, mb_idx, mb_ptr;

    always #5 clk = ~clk;

    prio_arbiter #(.N(8)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .mode(mode_a), .gnt_ready(rdy_a),
        .gnt_valid(v_a), .gnt_idx(idx_a), .gnt_onehot(oh_a)
    );

    prio_arbiter #(.N(5)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .mode(mode_b), .gnt_ready(rdy_b),
        .gnt_valid(v_b), .gnt_idx(idx_b), .gnt_onehot(oh_b)
    );

    // First requester met walking start, start-1, ... with wrap; -1 if none.
    function automatic int pick(input int r, input int start, input int n);
        int c;
        pick = -1;
        for (int k = n - 1; k >= 0; k--) begin
            c = (start - k + n) % n;
            if (r[c]) pick = c;
        end
    endfunction

    function automatic int rr_next(input int w, input int n);
        return (w == 0) ? n - 1 : w - 1;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the N=8 instance.
    always @(posedge clk) begin
        if (rst_a) begin
            ma_valid <= 0; ma_idx <= 0; ma_ptr <= 7;
        end else if (ma_valid == 0) begin
            if (req_a != 8'd0) begin
                ma_valid <= 1;
                ma_idx   <= pick(int'(req_a), mode_a ? ma_ptr : 7, 8);
            end
        end else if (rdy_a) begin
            ma_ptr <= mode_a ? rr_next(ma_idx, 8) : ma_ptr;
            if (req_a != 8'd0) ma_idx <= pick(int'(req_a), mode_a ? rr_next(ma_idx, 8) : 7, 8);
            else begin ma_valid <= 0; ma_idx <= 0; end
        end
    end

    // Behavioural model of the N=5 instance.
    always @(posedge clk) begin
        if (rst_b) begin
            mb_valid <= 0; mb_idx <= 0; mb_ptr <= 4;
        end else if (mb_valid == 0) begin
            if (req_b != 5'd0) begin
                mb_valid <= 1;
                mb_idx   <= pick(int'(req_b), mode_b ? mb_ptr : 4, 5);
            end
        end else if (rdy_b) begin
            mb_ptr <= mode_b ? rr_next(mb_idx, 5) : mb_ptr;
            if (req_b != 5'd0) mb_idx <= pick(int'(req_b), mode_b ? rr_next(mb_idx, 5) : 4, 5);
            else begin mb_valid <= 0; mb_idx <= 0; end
        end
    end

    // Per-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a_valid",  32'(v_a),   32'(ma_valid));
            cmp("a_idx",    32'(idx_a), 32'(ma_idx));
            cmp("a_onehot", 32'(oh_a),  ma_valid != 0 ? (32'd1 << ma_idx) : 32'd0);
            cmp("b_valid",  32'(v_b),   32'(mb_valid));
            cmp("b_idx",    32'(idx_b), 32'(mb_idx));
            cmp("b_onehot", 32'(oh_b),  mb_valid != 0 ? (32'd1 << mb_idx) : 32'd0);
            cmp("b_idx_range", 32'(idx_b < 3'd5), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit_a(input string nm, input logic ev, input logic [2:0] ei);
        cmp({nm, "_valid"}, 32'(v_a), 32'(ev));
        cmp({nm, "_idx"},   32'(idx_a), 32'(ei));
    endtask

    initial begin
        int rr_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        int b_seq  [3] = '{4, 0, 4};

        rst_a = 1'b1; req_a = 8'hFF; rdy_a = 1'b1; mode_a = 1'b0;
        rst_b = 1'b1; req_b = 5'd0;  rdy_b = 1'b1; mode_b = 1'b1;

        // Reset held two cycles with all requests up.
        tick();
        chk_en = 1'b1;
        lit_a("rst1", 1'b0, 3'd0);
        cmp("rst1_onehot", 32'(oh_a), 32'd0);
        tick();
        lit_a("rst2", 1'b0, 3'd0);
        cmp("rst2_onehot", 32'(oh_a), 32'd0);
        rst_a = 1'b0;
        tick();
        lit_a("first_grant", 1'b1, 3'd7);

        // Fixed priority: 5 beats 2 every cycle.
        req_a = 8'b0010_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit_a("fixed", 1'b1, 3'd5);
            cmp("fixed_onehot", 32'(oh_a), 32'h20);
        end
        req_a = 8'h00;
        tick();
        lit_a("fixed_idle", 1'b0, 3'd0);

        // Round-robin rotation over all requesters.
        mode_a = 1'b1; req_a = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            lit_a("rr_rot", 1'b1, 3'(rr_seq[i]));
        end

        // Backpressure: grant held while the consumer stalls.
        req_a = 8'h00;
        tick();
        lit_a("bp_idle", 1'b0, 3'd0);
        req_a = 8'h10;
        tick();
        lit_a("bp_grant", 1'b1, 3'd4);
        rdy_a = 1'b0; req_a = 8'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit_a("bp_hold", 1'b1, 3'd4);
            cmp("bp_hold_onehot", 32'(oh_a), 32'h10);
        end
        rdy_a = 1'b1;
        tick();
        lit_a("bp_release", 1'b1, 3'd7);
        req_a = 8'h00;
        tick();
        lit_a("bp_drain", 1'b0, 3'd0);

        // Wrap between requesters 1 and 0, then reset during a stall.
        req_a = 8'h03;
        tick(); lit_a("wrap0", 1'b1, 3'd1);
        tick(); lit_a("wrap1", 1'b1, 3'd0);
        tick(); lit_a("wrap2", 1'b1, 3'd1);
        tick(); lit_a("wrap3", 1'b1, 3'd0);
        tick(); lit_a("wrap4", 1'b1, 3'd1);
        rdy_a = 1'b0;
        tick(); lit_a("wrap_stall", 1'b1, 3'd1);
        rst_a = 1'b1; rdy_a = 1'b1;
        tick();
        lit_a("midop_rst", 1'b0, 3'd0);
        cmp("midop_rst_onehot", 32'(oh_a), 32'd0);
        rst_a = 1'b0; rdy_a = 1'b0; req_a = 8'h81;
        tick(); lit_a("post_rst", 1'b1, 3'd7);
        tick(); lit_a("post_rst_hold", 1'b1, 3'd7);

        // Non-power-of-two instance, round-robin.
        rst_b = 1'b0; req_b = 5'b10001;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("npo2_valid", 32'(v_b), 32'd1);
            cmp("npo2_idx",   32'(idx_b), 32'(b_seq[i]));
        end
        tick();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered N-way priority arbiter with a valid/ready grant handshake. It generalises the team's 8-to-3 combinational priority encoder:
- the request count is configurable;
- a run-time mode selects fixed priority (highest index wins) or round-robin;
- the winner is registered and held stable until the consumer accepts it.

It sits between a set of requesting channels and a shared single-issue resource such as a bus port or a FIFO write side.

## Interface
Parameters:
- N, 8, number of requesters, legal range 2..32
- W, $clog2(N), index width (derived; do not override)

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req  in  N  request vector; bit i = requester i wants a grant
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration points
- gnt_ready  in  1  consumer accepts the current grant
- gnt_valid  out  1  a grant is presented
- gnt_idx  out  W  binary index of the granted requester
- gnt_onehot  out  N  one-hot form of gnt_idx; all-zero when gnt_valid=0

## Operation
- **Reset values.** gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=N-1, state=IDLE.
- **Search order.** The search starts at ptr and descends with wrap: ptr, ptr-1, …, 0, N-1, …, ptr+1.
  - Fixed mode: the effective ptr is always N-1, so the MSB wins, as in the existing encoder.
  - Round-robin mode: the stored ptr is used.
- **State IDLE.**
  - req==0: stay in IDLE, gnt_valid=0.
  - req!=0: register the winner, go to GRANT.
- **State GRANT.**
  - gnt_valid=1; gnt_idx and gnt_onehot stay stable while gnt_ready=0, even if req changes or the granted bit drops.
  - Accept = gnt_valid && gnt_ready.
  - On accept in round-robin mode, ptr becomes (w==0 ? N-1 : w-1), where w is the accepted index. In fixed mode ptr is left unchanged.
  - In the accept cycle the block re-arbitrates combinationally on the current req, using the post-accept ptr:
    - req!=0: load the new winner and stay in GRANT.
    - req==0: go to IDLE and clear the outputs.
- **Mode changes.** mode is sampled only in an IDLE cycle with req!=0 or in an accept cycle. A change while a grant is held has no effect on that grant.
- **Reset mid-operation.** rst overrides everything, including an accept in the same cycle; the grant is dropped without being accepted.
- **Invariants.** gnt_onehot == (1<<gnt_idx) whenever gnt_valid=1. gnt_idx is always < N for non-power-of-two N.

## Timing
- Latency: req seen in IDLE at edge k gives gnt_valid=1 after edge k.
- Throughput: one grant per cycle while gnt_ready=1 and req!=0; there is no bubble between accepts.
- All outputs are registered; there is no combinational path from req, mode or gnt_ready to any output.
- Stall: while gnt_valid=1 && gnt_ready=0, all outputs and ptr hold.

## Structure
- Package arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
- Sub-module prio_enc_masked: purely combinational, parametrised by N.
  - Inputs: req and start index.
  - Outputs: found flag and winner index, with descending wrap search.
  - Implement it as a double-width (2N) highest-set-bit search.
- The top level holds the FSM, ptr register, output registers and accept logic.

## Test plan
All scenarios use N=8 unless stated otherwise.
- **Reset.** rst=1 for 2 cycles with req=8'hFF, gnt_ready=1 → gnt_valid=0, gnt_idx=0, gnt_onehot=0 throughout. First grant after release = idx 7.
- **Fixed priority.** mode=0, req=8'b0010_0100, gnt_ready=1 held → gnt_idx=5, gnt_onehot=8'h20 every cycle; idx 2 is never granted.
- **Round-robin rotation.** mode=1, req=8'hFF, gnt_ready=1 for 9 cycles → idx 7,6,5,4,3,2,1,0,7 on consecutive cycles, with no bubbles.
- **Backpressure.** Grant idx 4 (req=8'h10), then gnt_ready=0 for 3 cycles while req changes to 8'h80 → idx stays 4 and outputs hold. gnt_ready=1 → next cycle idx=7. req=0 after that → gnt_valid=0 and the FSM returns to IDLE.
- **Wrap and mid-op reset.** mode=1, req=8'h03 → idx 1,0,1,0. Then rst=1 during a stalled grant → next cycle gnt_valid=0 and ptr=7. Then req=8'h81 → idx 7.
- **Non-power-of-two.** N=5, W=3, mode=1, req=5'b10001 → idx 4, 0, 4; gnt_idx is never 5..7.
